seq_restoring_divider: RTL and testbench



---
 rtl/seq_restoring_divider.sv | 115 +++++++++++
 tb/tb_seq_restoring_divider.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock,
// with valid/ready handshakes on the operand and result sides.
module seq_restoring_divider #(
  parameter int N_W = 16,
  parameter int D_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N_W-1:0] dividend,
  input  logic [D_W-1:0] divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N_W-1:0] quotient,
  output logic [D_W-1:0] remainder,
  output logic           div_by_zero
);

  // state | meaning
  // IDLE  | waiting for operands, in_ready high
  // CALC  | shifting out one quotient bit per cycle
  // DONE  | result presented, waiting for out_ready
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  localparam int CNT_W = (N_W > 1) ? $clog2(N_W) : 1;

  state_t         r_state;
  state_t         w_next_state;
  logic [N_W-1:0] r_q;
  logic [D_W-1:0] r_p;
  logic [D_W-1:0] r_div;
  logic [CNT_W-1:0] r_count;
  logic           r_zero;
  logic           r_in_ready;
  logic [N_W-1:0] r_quot;
  logic [D_W-1:0] r_rem;
  logic           r_dbz;

  logic           w_accept;
  logic [D_W:0]   w_p_shift;
  logic [D_W:0]   w_trial;
  logic [N_W-1:0] w_q_next;
  logic [D_W-1:0] w_p_next;

  // The partial remainder never reaches the divisor between steps, so D_W
  // bits hold it; only the shifted value needs the extra bit.
  assign w_accept  = in_valid & r_in_ready;
  assign w_p_shift = {r_p, r_q[N_W-1]};
  assign w_trial   = w_p_shift - {1'b0, r_div};
  assign w_q_next  = {r_q[N_W-2:0], ~w_trial[D_W]};
  assign w_p_next  = w_trial[D_W] ? w_p_shift[D_W-1:0] : w_trial[D_W-1:0];

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_next_state = S_CALC;
      S_CALC:  if (r_count == '0) w_next_state = S_DONE;
      S_DONE:  if (out_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_q        <= '0;
      r_p        <= '0;
      r_div      <= '0;
      r_count    <= '0;
      r_zero     <= 1'b0;
      r_in_ready <= 1'b0;
      r_quot     <= '0;
      r_rem      <= '0;
      r_dbz      <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_in_ready <= (w_next_state == S_IDLE);
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_q    <= dividend;
            r_div  <= divisor;
            r_p    <= '0;
            r_zero <= (divisor == '0);
            // A zero divisor makes a single idle pass through CALC, giving
            // it a one-cycle result latency.
            r_count <= (divisor == '0) ? '0 : CNT_W'(N_W - 1);
          end
        end
        S_CALC: begin
          if (!r_zero) begin
            r_q <= w_q_next;
            r_p <= w_p_next;
          end
          if (r_count == '0) begin
            r_quot <= r_zero ? '1 : w_q_next;
            r_rem  <= r_zero ? r_q[D_W-1:0] : w_p_next;
            r_dbz  <= r_zero;
          end else begin
            r_count <= r_count - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = (r_state == S_DONE);
  assign quotient    = r_quot;
  assign remainder   = r_rem;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Bench for seq_restoring_divider: cycle model of the handshake/latency rules
// plus plain-arithmetic results, with directed and random operands.
module tb_seq_restoring_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  seq_restoring_divider #(.N_W(16), .D_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic wait_cycle();
    @(posedge clk);
    #1;
  endtask

  // Model: expected outputs for the current cycle, updated for the next one.
  bit          m_valid = 0, m_busy = 0, m_ir = 0, m_ov = 0, m_z = 0, p_z = 0;
  logic [15:0] m_q = '0, p_q = '0;
  logic [7:0]  m_r = '0, p_r = '0;
  int          cyc = 0, due = 0, n_acc = 0, n_done = 0;
  bit          rnd_en = 0;

  always @(negedge clk) begin
    if (m_valid) begin
      chk("in_ready", in_ready, m_ir);
      chk("out_valid", out_valid, m_ov);
      chk("quotient", quotient, m_q);
      chk("remainder", remainder, m_r);
      chk("div_by_zero", div_by_zero, m_z);
    end
    if (rst) begin
      m_valid = 1; m_busy = 0; m_ir = 0; m_ov = 0;
      m_q = '0; m_r = '0; m_z = 0;
      n_acc = n_done;
    end else if (m_valid) begin
      if (m_ir && in_valid) begin
        int ia, ib;
        ia = dividend;
        ib = divisor;
        m_busy = 1; m_ir = 0; n_acc++;
        if (ib == 0) begin
          p_q = 16'hFFFF; p_r = dividend[7:0]; p_z = 1; due = cyc + 2;
        end else begin
          p_q = 16'(ia / ib); p_r = 8'(ia % ib); p_z = 0; due = cyc + 17;
        end
      end else if (m_ov && out_ready) begin
        m_ov = 0; m_busy = 0; m_ir = 1; n_done++;
      end else if (!m_busy) begin
        m_ir = 1;
      end
      if (m_busy && !m_ov && (cyc + 1 == due)) begin
        m_ov = 1; m_q = p_q; m_r = p_r; m_z = p_z;
      end
    end
    cyc++;
  end

  always @(posedge clk) begin
    if (rnd_en) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic start_op(input logic [15:0] a, input logic [7:0] b);
    int n;
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    n = 0;
    while (!in_ready && n < 100) begin
      wait_cycle();
      n++;
    end
    if (n >= 100) begin
      n_chk++; n_fail++;
      $display("FAIL accept_timeout: in_ready low for %0d cycles, expected high", n);
    end
    wait_cycle();
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input int lat);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      wait_cycle();
      n++;
    end
    chk("latency", n, lat);
  endtask

  task automatic run_op(input logic [15:0] a, input logic [7:0] b,
                        input logic [15:0] eq, input logic [7:0] er,
                        input logic ez, input int lat);
    start_op(a, b);
    wait_result(lat);
    chk("lit_quotient", quotient, eq);
    chk("lit_remainder", remainder, er);
    chk("lit_div_by_zero", div_by_zero, ez);
    wait_cycle();
  endtask

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    dividend = '0; divisor = '0;
    repeat (3) wait_cycle();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    rst = 1'b0;
    wait_cycle();
    chk("post_rst_in_ready", in_ready, 1);

    run_op(16'd65025, 8'd255, 16'd255,   8'd0, 1'b0, 16);
    run_op(16'd1000,  8'd7,   16'd142,   8'd6, 1'b0, 16);
    run_op(16'd5,     8'd10,  16'd0,     8'd5, 1'b0, 16);
    run_op(16'd65535, 8'd1,   16'd65535, 8'd0, 1'b0, 16);
    run_op(16'd1234,  8'd0,   16'hFFFF,  8'hD2, 1'b1, 1);

    // backpressure then back-to-back operation
    out_ready = 1'b0;
    start_op(16'd1000, 8'd3);
    wait_result(16);
    repeat (5) begin
      wait_cycle();
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_quotient", quotient, 333);
      chk("bp_remainder", remainder, 1);
    end
    out_ready = 1'b1;
    wait_cycle();
    chk("hs_out_valid", out_valid, 0);
    chk("hs_in_ready", in_ready, 1);
    run_op(16'd200, 8'd13, 16'd15, 8'd5, 1'b0, 16);

    // reset in the 8th CALC cycle aborts the operation
    start_op(16'd40000, 8'd3);
    repeat (7) wait_cycle();
    rst = 1'b1;
    wait_cycle();
    rst = 1'b0;
    chk("abort_in_ready", in_ready, 0);
    wait_cycle();
    chk("abort_ready_after", in_ready, 1);
    repeat (25) begin
      wait_cycle();
      chk("abort_no_result", out_valid, 0);
    end
    run_op(16'd40000, 8'd3, 16'd13333, 8'd1, 1'b0, 16);

    // random operands with gaps and random backpressure
    rnd_en = 1;
    for (int i = 0; i < 2000; i++) begin
      repeat ($urandom_range(0, 3)) wait_cycle();
      start_op(16'($urandom), ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 255)));
    end
    n = 0;
    while (m_busy && n < 200) begin
      wait_cycle();
      n++;
    end
    if (n >= 200) begin
      n_chk++; n_fail++;
      $display("FAIL drain_timeout: result still pending after %0d cycles", n);
    end
    rnd_en = 0;
    wait_cycle();
    out_ready = 1'b1;
    repeat (3) wait_cycle();
    chk("results_vs_accepts", n_done, n_acc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
